// File: rtl/uart_wb_bridge.sv
// Serial command engine: parses W/R frames from the uart byte interface and runs Wishbone classic cycles.
// Optional WB_TIMEOUT_EN: abort a Wishbone cycle after TIMEOUT_CYCLES without ack and reply 'E'.
module uart_wb_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    input  logic        rx_error,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_BAD   = 8'h3F;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WB, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_q, resp_d;
    logic        resp_single_q, resp_single_d;
    logic        rx_ack_q, rx_ack_d;
    logic        tx_wr_q, tx_wr_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic        wb_we_q, wb_we_d;
    logic [31:0] wb_adr_q, wb_adr_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic        rx_err_take, rx_byte_take;

`ifdef WB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    // rx_avail/rx_error are stale while our own ack is still high
    assign rx_err_take  = rx_error && !rx_ack_q;
    assign rx_byte_take = rx_avail && !rx_ack_q && !rx_error;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_write_d    = is_write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        resp_d        = resp_q;
        resp_single_d = resp_single_q;
        rx_ack_d      = 1'b0;
        tx_wr_d       = 1'b0;
        tx_data_d     = tx_data_q;
        wb_cyc_d      = wb_cyc_q;
        wb_we_d       = wb_we_q;
        wb_adr_d      = wb_adr_q;
        wb_dat_d      = wb_dat_q;
`ifdef WB_TIMEOUT_EN
        tmo_d         = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_err_take) begin
                    rx_ack_d = 1'b1;
                end else if (rx_byte_take) begin
                    rx_ack_d = 1'b1;
                    cnt_d    = 2'd0;
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        is_write_d = (rx_data == CMD_WRITE);
                        state_d    = S_ADDR;
                    end else begin
                        resp_d        = {RSP_BAD, 24'h0};
                        resp_single_d = 1'b1;
                        state_d       = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_err_take) begin
                    rx_ack_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (rx_byte_take) begin
                    rx_ack_d = 1'b1;
                    addr_d   = {addr_q[23:0], rx_data};
                    cnt_d    = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_write_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d  = S_WB;
                            wb_cyc_d = 1'b1;
                            wb_we_d  = 1'b0;
                            wb_adr_d = {addr_q[23:0], rx_data};
                            wb_dat_d = wdata_q;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_err_take) begin
                    rx_ack_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (rx_byte_take) begin
                    rx_ack_d = 1'b1;
                    wdata_d  = {wdata_q[23:0], rx_data};
                    cnt_d    = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d  = S_WB;
                        wb_cyc_d = 1'b1;
                        wb_we_d  = 1'b1;
                        wb_adr_d = addr_q;
                        wb_dat_d = {wdata_q[23:0], rx_data};
                    end
                end
            end
            S_WB: begin
`ifdef WB_TIMEOUT_EN
                tmo_d = tmo_q + TW'(1);
`endif
                if (wb_ack_i) begin
                    wb_cyc_d = 1'b0;
                    wb_we_d  = 1'b0;
                    cnt_d    = 2'd0;
                    state_d  = S_RESP;
                    if (is_write_q) begin
                        resp_d        = {RSP_OK, 24'h0};
                        resp_single_d = 1'b1;
                    end else begin
                        resp_d        = wb_dat_i;
                        resp_single_d = 1'b0;
                    end
                end
`ifdef WB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    wb_cyc_d      = 1'b0;
                    wb_we_d       = 1'b0;
                    cnt_d         = 2'd0;
                    resp_d        = {8'h45, 24'h0};
                    resp_single_d = 1'b1;
                    state_d       = S_RESP;
                end
`endif
            end
            S_RESP: begin
                // tx_wr_q check covers the edge before the uart reflects busy
                if (!tx_busy && !tx_wr_q) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = resp_q[31:24];
                    resp_d    = {resp_q[23:0], 8'h0};
                    cnt_d     = cnt_q + 2'd1;
                    if (resp_single_q || cnt_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 2'd0;
            is_write_q    <= 1'b0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            resp_q        <= 32'h0;
            resp_single_q <= 1'b0;
            rx_ack_q      <= 1'b0;
            tx_wr_q       <= 1'b0;
            tx_data_q     <= 8'h0;
            wb_cyc_q      <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_adr_q      <= 32'h0;
            wb_dat_q      <= 32'h0;
`ifdef WB_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_write_q    <= is_write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            resp_q        <= resp_d;
            resp_single_q <= resp_single_d;
            rx_ack_q      <= rx_ack_d;
            tx_wr_q       <= tx_wr_d;
            tx_data_q     <= tx_data_d;
            wb_cyc_q      <= wb_cyc_d;
            wb_we_q       <= wb_we_d;
            wb_adr_q      <= wb_adr_d;
            wb_dat_q      <= wb_dat_d;
`ifdef WB_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign rx_ack   = rx_ack_q;
    assign tx_wr    = tx_wr_q;
    assign tx_data  = tx_data_q;
    assign wb_cyc_o = wb_cyc_q;
    assign wb_stb_o = wb_cyc_q;
    assign wb_we_o  = wb_we_q;
    assign wb_adr_o = wb_adr_q;
    assign wb_dat_o = wb_dat_q;
    assign wb_sel_o = 4'hF;
endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: uart byte-side model, Wishbone slave model, transmit capture.
module tb_uart_wb_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_avail = 1'b0;
    logic        rx_error = 1'b0;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;

    int total = 0;
    int bad = 0;

    // uart transmitter model
    logic       force_busy = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] tx_q[$];
    int         tx_viol = 0;
    logic       tx_wr_prev = 1'b0;
    assign tx_busy = force_busy || (busy_cnt != 0);

    // Wishbone slave model
    int          slave_delay = 0;
    logic        slave_comb = 1'b0;
    logic        slave_never = 1'b0;
    logic [31:0] slave_rdata = 32'h0;
    logic        ack_q = 1'b0;
    int          wait_cnt = 0;
    int          wb_cnt = 0;
    int          cyc_starts = 0;
    int          cyc_cycles = 0;
    logic        cyc_prev = 1'b0;
    logic [31:0] last_adr = 32'h0, last_dat = 32'h0;
    logic        last_we = 1'b0;
    logic [3:0]  last_sel = 4'h0;
    int          rx_ack_cnt = 0;

    assign wb_dat_i = slave_rdata;
    assign wb_ack_i = ack_q | (slave_comb & wb_cyc_o & wb_stb_o);

    uart_wb_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tx_wr_prev <= tx_wr;
        if (tx_wr) begin
            tx_q.push_back(tx_data);
            busy_cnt <= 4;
            if (tx_busy || tx_wr_prev) tx_viol <= tx_viol + 1;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (rx_ack) rx_ack_cnt <= rx_ack_cnt + 1;
    end

    always @(posedge clk) begin
        cyc_prev <= wb_cyc_o;
        if (wb_cyc_o) cyc_cycles <= cyc_cycles + 1;
        if (wb_cyc_o && !cyc_prev) cyc_starts <= cyc_starts + 1;
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            wb_cnt   <= wb_cnt + 1;
            last_adr <= wb_adr_o;
            last_dat <= wb_dat_o;
            last_we  <= wb_we_o;
            last_sel <= wb_sel_o;
        end
        if (wb_cyc_o && wb_stb_o && !ack_q && !slave_comb) begin
            if (!slave_never && wait_cnt >= slave_delay) ack_q <= 1'b1;
            else wait_cnt <= wait_cnt + 1;
        end else begin
            ack_q    <= 1'b0;
            wait_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a byte (or a framing error) and hold it until the cycle after rx_ack.
    task automatic send_byte(input logic [7:0] b, input logic err);
        int k;
        rx_data  = b;
        rx_avail = !err;
        rx_error = err;
        for (k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (rx_ack) break;
        end
        chk("rx_consumed", {31'b0, rx_ack}, 32'd1);
        @(posedge clk); #1;
        rx_avail = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b0);
        send_byte(w[23:16], 1'b0);
        send_byte(w[15:8], 1'b0);
        send_byte(w[7:0], 1'b0);
    endtask

    task automatic wait_tx(input int target, input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            if (tx_q.size() >= target) break;
            @(posedge clk); #1;
        end
        chk("tx_count_reached", {31'b0, tx_q.size() >= target}, 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int tb0, wb0, ack0;
        tb0 = tx_q.size(); wb0 = wb_cnt; ack0 = rx_ack_cnt;
        send_byte(8'h57, 1'b0);
        send_word(a);
        send_word(d);
        wait_tx(tb0 + 1, 200);
        repeat (10) @(posedge clk);
        #1;
        chk("wr_wb_count", wb_cnt - wb0, 32'd1);
        chk("wr_adr", last_adr, a);
        chk("wr_dat", last_dat, d);
        chk("wr_we", {31'b0, last_we}, 32'd1);
        chk("wr_sel", {28'b0, last_sel}, 32'hF);
        chk("wr_reply", {24'b0, tx_q[tb0]}, 32'h4B);
        chk("wr_reply_len", tx_q.size() - tb0, 32'd1);
        chk("wr_rx_acks", rx_ack_cnt - ack0, 32'd9);
        $display("txn write adr=%h dat=%h reply=%h", a, d, tx_q[tb0]);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int limit);
        int tb0, wb0;
        tb0 = tx_q.size(); wb0 = wb_cnt;
        slave_rdata = d;
        send_byte(8'h52, 1'b0);
        send_word(a);
        wait_tx(tb0 + 4, limit);
        repeat (10) @(posedge clk);
        #1;
        chk("rd_wb_count", wb_cnt - wb0, 32'd1);
        chk("rd_adr", last_adr, a);
        chk("rd_we", {31'b0, last_we}, 32'd0);
        chk("rd_reply_len", tx_q.size() - tb0, 32'd4);
        if (tx_q.size() >= tb0 + 4) begin
            chk("rd_data", {tx_q[tb0], tx_q[tb0+1], tx_q[tb0+2], tx_q[tb0+3]}, d);
            $display("txn read adr=%h data=%h%h%h%h", a, tx_q[tb0], tx_q[tb0+1], tx_q[tb0+2], tx_q[tb0+3]);
        end
    endtask

    initial begin
        int tb0, wb0, ack0, cs0, k;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;
        @(negedge clk);
        chk("rst_rx_ack", {31'b0, rx_ack}, 32'd0);
        chk("rst_tx_wr", {31'b0, tx_wr}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("rst_we", {31'b0, wb_we_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_sel", {28'b0, wb_sel_o}, 32'hF);
        $display("txn reset checked");

        do_write(32'h1000_0004, 32'hDEAD_BEEF);

        slave_delay = 3;
        do_read(32'h0000_0008, 32'h1234_5678, 300);

        // unknown command, then a read acked in the first cyc cycle
        tb0 = tx_q.size(); cs0 = cyc_starts;
        send_byte(8'h41, 1'b0);
        wait_tx(tb0 + 1, 100);
        repeat (10) @(posedge clk);
        #1;
        chk("unk_reply", {24'b0, tx_q[tb0]}, 32'h3F);
        chk("unk_reply_len", tx_q.size() - tb0, 32'd1);
        chk("unk_no_wb", cyc_starts - cs0, 32'd0);
        $display("txn unknown cmd=41 reply=%h", tx_q[tb0]);
        slave_comb = 1'b1;
        do_read(32'h0000_0020, 32'hA5A5_0F0F, 300);
        slave_comb = 1'b0;

        // framing error mid-command
        tb0 = tx_q.size(); cs0 = cyc_starts; ack0 = rx_ack_cnt;
        send_byte(8'h57, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        chk("ferr_no_wb", cyc_starts - cs0, 32'd0);
        chk("ferr_no_tx", tx_q.size() - tb0, 32'd0);
        chk("ferr_rx_acks", rx_ack_cnt - ack0, 32'd4);
        $display("txn framing error aborted partial write");
        do_write(32'h0000_0100, 32'h0102_0304);

        // backpressure on the read reply
        force_busy = 1'b1;
        tb0 = tx_q.size(); wb0 = wb_cnt;
        slave_delay = 1;
        slave_rdata = 32'hCAFE_F00D;
        send_byte(8'h52, 1'b0);
        send_word(32'h0000_0030);
        for (k = 0; k < 100; k++) begin
            if (wb_cnt != wb0) break;
            @(posedge clk); #1;
        end
        chk("bp_wb_done", wb_cnt - wb0, 32'd1);
        repeat (500) @(posedge clk);
        #1;
        chk("bp_no_tx_while_busy", tx_q.size() - tb0, 32'd0);
        force_busy = 1'b0;
        wait_tx(tb0 + 4, 200);
        repeat (50) @(posedge clk);
        #1;
        chk("bp_reply_len", tx_q.size() - tb0, 32'd4);
        if (tx_q.size() >= tb0 + 4)
            chk("bp_data", {tx_q[tb0], tx_q[tb0+1], tx_q[tb0+2], tx_q[tb0+3]}, 32'hCAFE_F00D);
        $display("txn backpressured read reply count=%0d", tx_q.size() - tb0);

        // reset while a Wishbone cycle is open
        slave_never = 1'b1;
        send_byte(8'h52, 1'b0);
        send_word(32'h0000_0040);
        for (k = 0; k < 50; k++) begin
            if (wb_cyc_o) break;
            @(posedge clk); #1;
        end
        chk("rstwb_cyc_open", {31'b0, wb_cyc_o}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstwb_cyc_drop", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
        reset = 1'b0;
        slave_never = 1'b0;
        $display("txn reset during wishbone cycle");
        do_read(32'h0000_0044, 32'h0BAD_F00D, 300);

`ifdef WB_TIMEOUT_EN
        slave_never = 1'b1;
        tb0 = tx_q.size(); cs0 = cyc_cycles;
        send_byte(8'h52, 1'b0);
        send_word(32'h0000_0050);
        wait_tx(tb0 + 1, 300);
        repeat (10) @(posedge clk);
        #1;
        chk("tmo_cyc_cycles", cyc_cycles - cs0, 32'd16);
        chk("tmo_reply", {24'b0, tx_q[tb0]}, 32'h45);
        chk("tmo_reply_len", tx_q.size() - tb0, 32'd1);
        $display("txn timeout reply=%h", tx_q[tb0]);
        slave_never = 1'b0;
`endif

        chk("tx_protocol_violations", tx_viol, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
